// File: rtl/norm_pkg.sv
// norm_pkg: shared definitions for the divider arbiter slice.
//   state_t  - arbiter FSM states
//   norm_w   - datapath width from the fractional extension S (W = S+8)
//   norm_iw  - requester id width from the requester count N
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int norm_w(input int s);
    return s + 8;
  endfunction

  function automatic int norm_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/norm_div_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req       in   N   per-requester request
//   rr_ptr    in   IW  highest-priority requester for this pick
//   grant_vld out  1   at least one request present
//   grant_id  out  IW  first requester with req set, searching upward from rr_ptr, wrapping mod N
module rr_pick
  import norm_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = norm_iw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          grant_vld,
  output logic [IW-1:0] grant_id
);

  localparam logic [IW:0] N_V = (IW+1)'(N);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  // Walk from the farthest offset down to offset 0 so the requester nearest
  // to rr_ptr is the last one written and therefore wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (w_sum >= N_V) begin
        w_sum = w_sum - N_V;
      end
      w_idx = w_sum[IW-1:0];
      if (req[w_idx]) begin
        grant_vld = 1'b1;
        grant_id  = w_idx;
      end
    end
  end

endmodule

// File: rtl/norm_div_arbiter.sv
// norm_div_arbiter: round-robin sequencer sharing one norm_mid non-restoring
// divider between N requesters. Latches the granted requester's operands,
// pulses the divider start, waits for the divide and returns A/Q tagged with
// the requester id.
// Ports:
//   MHz10, nrst (async, active-low), en (global enable, freezes FSM)
//   req[N], a_in/q_in/m_in[N*W] (requester k at [k*W +: W])
//   done[N] one-hot pulse, res_a/res_q[W], res_id[IW], res_err
//   div_en, div_start, div_a/div_q/div_m[W] -> divider
//   div_ready, div_a_o, div_q_o            <- divider
// Optional feature macro: DIV_ZERO_TRAP_EN (M=0 answered locally in 2 cycles
// with res_q all ones and res_err set; the divider is not started).
module norm_div_arbiter
  import norm_pkg::*;
#(
  parameter  int S  = 8,
  parameter  int D  = 8,
  parameter  int N  = 4,
  localparam int W  = norm_w(S),
  localparam int IW = norm_iw(N)
) (
  input  logic            MHz10,
  input  logic            nrst,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  a_in,
  input  logic [N*W-1:0]  q_in,
  input  logic [N*W-1:0]  m_in,
  output logic [N-1:0]    done,
  output logic [W-1:0]    res_a,
  output logic [W-1:0]    res_q,
  output logic [IW-1:0]   res_id,
  output logic            res_err,
  output logic            div_en,
  output logic            div_start,
  output logic [W-1:0]    div_a,
  output logic [W-1:0]    div_q,
  output logic [W-1:0]    div_m,
  input  logic            div_ready,
  input  logic [W-1:0]    div_a_o,
  input  logic [W-1:0]    div_q_o
);

  if (N < 2 || N > 8 || D < 1) begin : g_param_check
    $error("norm_div_arbiter: N must be 2..8 and D at least 1");
  end

  state_t        r_state, w_state_next;
  logic [IW-1:0] r_rr_ptr, r_cur_id, r_res_id;
  logic [W-1:0]  r_div_a, r_div_q, r_div_m;
  logic [W-1:0]  r_res_a, r_res_q;

  logic          w_grant_vld;
  logic [IW-1:0] w_grant_id, w_ptr_next;
  logic [W-1:0]  w_a_arr [N];
  logic [W-1:0]  w_q_arr [N];
  logic [W-1:0]  w_m_arr [N];
  logic [W-1:0]  w_gnt_a, w_gnt_q, w_gnt_m;
  logic          w_grant, w_capture, w_trap_hit, w_trap_pend;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_a_arr[gi] = a_in[gi*W +: W];
    assign w_q_arr[gi] = q_in[gi*W +: W];
    assign w_m_arr[gi] = m_in[gi*W +: W];
  end

  rr_pick #(.N(N)) u_rr_pick (
    .req       (req),
    .rr_ptr    (r_rr_ptr),
    .grant_vld (w_grant_vld),
    .grant_id  (w_grant_id)
  );

  assign w_gnt_a    = w_a_arr[w_grant_id];
  assign w_gnt_q    = w_q_arr[w_grant_id];
  assign w_gnt_m    = w_m_arr[w_grant_id];
  assign w_ptr_next = (w_grant_id == IW'(N - 1)) ? '0 : w_grant_id + 1'b1;

`ifdef DIV_ZERO_TRAP_EN
  logic r_trap, r_res_err;

  // A zero divisor goes straight to WAIT with r_trap set; WAIT then captures
  // the trap result instead of the divider outputs, giving done two cycles
  // after the grant without ever starting the divider.
  assign w_trap_hit  = (w_gnt_m == '0);
  assign w_trap_pend = r_trap;
  assign res_err     = r_res_err;

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      r_trap    <= 1'b0;
      r_res_err <= 1'b0;
    end else if (en) begin
      if (w_grant) begin
        r_trap <= w_trap_hit;
      end
      if (w_capture) begin
        r_res_err <= r_trap;
      end
    end
  end
`else
  assign w_trap_hit  = 1'b0;
  assign w_trap_pend = 1'b0;
  assign res_err     = 1'b0;
`endif

  assign w_grant   = (r_state == IDLE) && w_grant_vld;
  assign w_capture = (r_state == WAIT) && (div_ready || w_trap_pend);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_next = w_trap_hit ? WAIT : ISSUE;
      ISSUE:   if (div_ready) w_state_next = WAIT;
      WAIT:    if (div_ready || w_trap_pend) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    done = '0;
    if (r_state == RESP) begin
      done[r_cur_id] = 1'b1;
    end
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_cur_id <= '0;
      r_div_a  <= '0;
      r_div_q  <= '0;
      r_div_m  <= '0;
      r_res_a  <= '0;
      r_res_q  <= '0;
      r_res_id <= '0;
    end else if (en) begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_div_a  <= w_gnt_a;
        r_div_q  <= w_gnt_q;
        r_div_m  <= w_gnt_m;
        r_cur_id <= w_grant_id;
        r_rr_ptr <= w_ptr_next;
      end
      if (w_capture) begin
        r_res_a  <= w_trap_pend ? r_div_a : div_a_o;
        r_res_q  <= w_trap_pend ? '1 : div_q_o;
        r_res_id <= r_cur_id;
      end
    end
  end

  assign div_en    = en;
  assign div_start = (r_state == ISSUE);
  assign div_a     = r_div_a;
  assign div_q     = r_div_q;
  assign div_m     = r_div_m;
  assign res_a     = r_res_a;
  assign res_q     = r_res_q;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_norm_div_arbiter.sv
// tb_norm_div_arbiter: self-checking bench for norm_div_arbiter (S=8, D=8, N=4).
// Contains a behavioural stand-in for the norm_mid non-restoring divider.
`timescale 1ns/1ps
module tb_norm_div_arbiter;

  localparam int S  = 8;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic            MHz10 = 1'b0;
  logic            nrst;
  logic            en;
  logic [N-1:0]    req;
  logic [N*W-1:0]  a_in, q_in, m_in;
  logic [N-1:0]    done;
  logic [W-1:0]    res_a, res_q;
  logic [IW-1:0]   res_id;
  logic            res_err;
  logic            div_en, div_start;
  logic [W-1:0]    div_a, div_q, div_m;
  logic            div_ready;
  logic [W-1:0]    div_a_o, div_q_o;

  always #50 MHz10 = ~MHz10;

  norm_div_arbiter #(.S(S), .D(D), .N(N)) dut (
    .MHz10(MHz10), .nrst(nrst), .en(en), .req(req),
    .a_in(a_in), .q_in(q_in), .m_in(m_in),
    .done(done), .res_a(res_a), .res_q(res_q), .res_id(res_id), .res_err(res_err),
    .div_en(div_en), .div_start(div_start),
    .div_a(div_a), .div_q(div_q), .div_m(div_m),
    .div_ready(div_ready), .div_a_o(div_a_o), .div_q_o(div_q_o)
  );

  // ---------------- divider stand-in (D-iteration non-restoring) ----------
  logic [W-1:0] dv_a, dv_q, dv_m;
  logic         dv_ready;
  int           dv_cnt;

  assign div_ready = dv_ready;
  assign div_a_o   = dv_a;
  assign div_q_o   = dv_q;

  function automatic logic [2*W-1:0] nr_step(input logic [W-1:0] a, input logic [W-1:0] q,
                                             input logic [W-1:0] m);
    logic [2*W-1:0] aq;
    logic [W-1:0]   na;
    aq = {a, q} << 1;
    na = aq[2*W-1:W];
    if (a[W-1]) na = na + m;
    else        na = na - m;
    return {na, aq[W-1:1], ~na[W-1]};
  endfunction

  always @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      dv_a <= '0; dv_q <= '0; dv_m <= '0; dv_ready <= 1'b1; dv_cnt <= 0;
    end else if (div_en) begin
      if (dv_cnt != 0) begin
        {dv_a, dv_q} <= nr_step(dv_a, dv_q, dv_m);
        dv_cnt <= dv_cnt - 1;
        if (dv_cnt == 1) dv_ready <= 1'b1;
      end else if (div_start && dv_ready) begin
        dv_a <= div_a; dv_q <= div_q; dv_m <= div_m;
        dv_cnt <= D; dv_ready <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard and checking --------------------------------
  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] q;
    logic         err;
    int           cyc;
    bit           clr;
  } exp_t;

  typedef struct {
    int           id;
    logic [W-1:0] a_op, q_op, m_op;
    logic [W-1:0] exp_a, exp_q;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   start_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Expected divider result for a=0, q = X<<8: quotient X/M in the low byte,
  // uncorrected remainder is r when the quotient is odd, r-M otherwise.
  // M=0 never subtracts: A collects X, every quotient bit is 1.
  task automatic ref_div(input logic [W-1:0] q, input logic [W-1:0] m,
                         output logic [W-1:0] ea, output logic [W-1:0] eq);
    int x, qu, r;
    x = int'(q[15:8]);
    if (m == 0) begin
      ea = W'(x);
      eq = {q[7:0], 8'hFF};
    end else begin
      qu = x / int'(m);
      r  = x % int'(m);
      ea = (qu % 2 == 1) ? W'(r) : W'(r - int'(m));
      eq = {q[7:0], 8'(qu)};
    end
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] q,
                         input logic [W-1:0] m);
    a_in[id*W +: W] = a;
    q_in[id*W +: W] = q;
    m_in[id*W +: W] = m;
  endtask

  task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] q,
                      input logic err, input int at, input bit clr);
    exp_t e;
    e.id = id; e.a = a; e.q = q; e.err = err; e.cyc = at; e.clr = clr;
    sb.push_back(e);
  endtask

  task automatic push_ref(input int id, input int at, input bit clr);
    logic [W-1:0] ea, eq;
    ref_div(q_in[id*W +: W], m_in[id*W +: W], ea, eq);
    push(id, ea, eq, 1'b0, at, clr);
  endtask

  task automatic step();
    exp_t e;
    @(posedge MHz10);
    #1;
    cyc++;
    if (div_start) start_cnt++;
    if (done != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        e = sb.pop_front();
        $display("done cyc=%0d id=%0d res_a=%h res_q=%h err=%0b", cyc, res_id, res_a, res_q, res_err);
        chk("done_vec", 32'(done), 32'(1) << e.id);
        chk("res_id",   32'(res_id), 32'(e.id));
        chk("res_a",    32'(res_a), 32'(e.a));
        chk("res_q",    32'(res_q), 32'(e.q));
        chk("res_err",  32'(res_err), 32'(e.err));
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
        if (e.clr) req[e.id] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) step();
    chk("drain_timeout", 32'(sb.size()), 32'h0);
    step();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_done"},  32'(done), 32'h0);
    chk({tag, "_res_a"}, 32'(res_a), 32'h0);
    chk({tag, "_res_q"}, 32'(res_q), 32'h0);
    chk({tag, "_res_id"}, 32'(res_id), 32'h0);
    chk({tag, "_res_err"}, 32'(res_err), 32'h0);
    chk({tag, "_start"}, 32'(div_start), 32'h0);
    chk({tag, "_div_a"}, 32'(div_a), 32'h0);
    chk({tag, "_div_q"}, 32'(div_q), 32'h0);
    chk({tag, "_div_m"}, 32'(div_m), 32'h0);
  endtask

  vec_t vt[4];
  int   c0;

  initial begin
    // Last row uses id 3 so the round-robin pointer ends back at 0.
    vt[0] = '{2, 16'h0000, 16'h6400, 16'h0003, 16'h0001, 16'h0021};
    vt[1] = '{0, 16'h0000, 16'hC800, 16'h0007, 16'hFFFD, 16'h001C};
    vt[2] = '{1, 16'h0000, 16'hFF00, 16'h0010, 16'h000F, 16'h000F};
    vt[3] = '{3, 16'h0000, 16'h0100, 16'h0005, 16'hFFFC, 16'h0000};

    nrst = 1'b1; en = 1'b1; req = '0; a_in = '0; q_in = '0; m_in = '0;
    #2 nrst = 1'b0;
    #1 chk_zero_outputs("reset");
    step(); step();
    nrst = 1'b1;
    step();

    // Single requests from the table; done 11 cycles after the request.
    for (int k = 0; k < 4; k++) begin
      set_ops(vt[k].id, vt[k].a_op, vt[k].q_op, vt[k].m_op);
      push(vt[k].id, vt[k].exp_a, vt[k].exp_q, 1'b0, cyc + 11, 1'b1);
      req[vt[k].id] = 1'b1;
      drain();
      if (k == 0) begin
        step(); step();
        chk("hold_res_q", 32'(res_q), 32'h0021);
        chk("hold_res_id", 32'(res_id), 32'h2);
      end
    end

    // All four at once, pointer at 0: served 0,1,2,3 twelve cycles apart.
    set_ops(0, 16'h0000, 16'h3000, 16'h0004);
    set_ops(1, 16'h0000, 16'h6300, 16'h0009);
    set_ops(2, 16'h0000, 16'hFE00, 16'h000D);
    set_ops(3, 16'h0000, 16'h0700, 16'h0002);
    for (int k = 0; k < 4; k++) push_ref(k, cyc + 11 + 12 * k, 1'b1);
    req = 4'b1111;
    drain();

    // req[1] held across its done, req[3] arrives mid-divide: 3 wins next.
    set_ops(1, 16'h0000, 16'h5A00, 16'h0006);
    set_ops(3, 16'h0000, 16'h8100, 16'h000B);
    c0 = cyc;
    push_ref(1, c0 + 11, 1'b0);
    req[1] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    req[3] = 1'b1;
    push_ref(3, c0 + 23, 1'b1);
    push_ref(1, c0 + 35, 1'b1);
    drain();

    // en low for 5 cycles in WAIT; operands changed after grant are ignored.
    set_ops(0, 16'h0000, 16'h4B00, 16'h0005);
    c0 = cyc;
    push_ref(0, c0 + 16, 1'b1);
    req[0] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    set_ops(0, 16'h0000, 16'hFF00, 16'h0001);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b1;
    drain();

    // Reset during WAIT: no done, everything cleared, then a fresh request.
    set_ops(2, 16'h0000, 16'h6400, 16'h0003);
    req[2] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    req = '0;
    nrst = 1'b0;
    #1 chk_zero_outputs("midreset");
    step(); step();
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) step();
    set_ops(1, 16'h0000, 16'h6400, 16'h0003);
    push(1, 16'h0001, 16'h0021, 1'b0, cyc + 11, 1'b1);
    req[1] = 1'b1;
    drain();

    // Zero divisor on requester 0.
    start_cnt = 0;
`ifdef DIV_ZERO_TRAP_EN
    set_ops(0, 16'h1234, 16'h0500, 16'h0000);
    push(0, 16'h1234, 16'hFFFF, 1'b1, cyc + 2, 1'b1);
    req[0] = 1'b1;
    drain();
    chk("trap_no_start", 32'(start_cnt), 32'h0);
`else
    set_ops(0, 16'h0000, 16'h0500, 16'h0000);
    push(0, 16'h0005, 16'h00FF, 1'b0, cyc + 11, 1'b1);
    req[0] = 1'b1;
    drain();
    chk("m0_one_start", 32'(start_cnt), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
